div16u8_seq: RTL and testbench

DIV16U8_SEQ -- requirements
Module: div16u8_seq

---
 rtl/div16u8_seq.sv | 75 +++++++
 tb/tb_div16u8_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div16u8_seq.sv
// div16u8_seq: sequential 16/8 unsigned restoring divider; define DIV16U8_SEQ_APPROX_EN for the 12-step approximate mode
module div16u8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`ifdef DIV16U8_SEQ_APPROX_EN
  localparam logic [3:0] LAST = 4'd11;
`else
  localparam logic [3:0] LAST = 4'd15;
`endif
  state_t      state, state_nx;
  logic [15:0] aq, aq_nx, q_fin;
  logic [7:0]  p, p_nx, b, r_fin;
  logic [8:0]  t;
  logic [3:0]  cnt;
  logic        ge;
  // one restoring-division step; P stays below B so it never needs its ninth bit
  always_comb begin
    t     = {p, aq[15]};
    ge    = t >= {1'b0, b};
    aq_nx = {aq[14:0], ge};
    p_nx  = ge ? 8'(t - {1'b0, b}) : t[7:0];
`ifdef DIV16U8_SEQ_APPROX_EN
    q_fin = {aq_nx[11:0], 4'd0};
    r_fin = 8'd0;
`else
    q_fin = aq_nx;
    r_fin = p_nx;
`endif
  end
  // next-state and handshake outputs
  always_comb begin
    state_nx  = state == IDLE ? (in_valid ? (B == 8'd0 ? DONE : BUSY) : IDLE)
              : state == BUSY ? (cnt == LAST ? DONE : BUSY)
              : (out_ready ? IDLE : DONE);
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aq <= '0; p <= '0; b <= '0; cnt <= '0;
      Q <= '0; R <= '0; div_by_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      aq <= A; b <= B; p <= '0; cnt <= '0;
      div_by_zero <= B == 8'd0;
      if (B == 8'd0) begin
        Q <= 16'hFFFF;
        R <= A[7:0];
      end
    end else if (state == BUSY) begin
      aq  <= aq_nx;
      p   <= p_nx;
      cnt <= cnt + 4'd1;
      if (cnt == LAST) begin
        Q <= q_fin;
        R <= r_fin;
      end
    end
  end
endmodule

// File: tb/tb_div16u8_seq.sv
// tb_div16u8_seq: directed and random checks of the sequential divider
module tb_div16u8_seq;
  logic        clk = 1'b0, rst_n, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  b = '0;
  logic        in_ready, out_valid, div_by_zero;
  logic [15:0] q;
  logic [7:0]  r;
  int n_chk = 0, n_fail = 0;
`ifdef DIV16U8_SEQ_APPROX_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 16;
`endif

  div16u8_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .Q(q), .R(r),
    .div_by_zero(div_by_zero));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mq(input logic [15:0] x, input logic [7:0] y);
`ifdef DIV16U8_SEQ_APPROX_EN
    return ((x >> 4) / 16'(y)) << 4;
`else
    return x / 16'(y);
`endif
  endfunction

  function automatic logic [7:0] mr(input logic [15:0] x, input logic [7:0] y);
`ifdef DIV16U8_SEQ_APPROX_EN
    return 8'd0;
`else
    return 8'(x % 16'(y));
`endif
  endfunction

  // called #1 after a rising edge with the block idle
  task automatic start(input logic [15:0] x, input logic [7:0] y);
    chk("ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic res(input string tag, input logic [15:0] eq, input logic [7:0] er, input logic ed);
    chk({tag, "_Q"}, 32'(q), 32'(eq));
    chk({tag, "_R"}, 32'(r), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ed));
  endtask

  task automatic retire;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_retire", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    chk("reset_hs", {30'd0, in_ready, out_valid}, 32'b10);
    res("reset", 16'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    start(16'd1000, 8'd7);
    chk("busy_not_ready", 32'(in_ready), 0);
    wait_done(LAT);
    res("1000/7", mq(16'd1000, 8'd7), mr(16'd1000, 8'd7), 1'b0);
    retire;

    start(16'd65535, 8'd1);   wait_done(LAT); res("65535/1", mq(16'd65535, 8'd1), mr(16'd65535, 8'd1), 1'b0); retire;
    start(16'd65535, 8'd255); wait_done(LAT); res("65535/255", mq(16'd65535, 8'd255), 8'd0, 1'b0); retire;
    start(16'd5, 8'd200);     wait_done(LAT); res("5/200", 16'd0, mr(16'd5, 8'd200), 1'b0); retire;

    start(16'd255, 8'd0);
    chk("dbz_valid_at_once", 32'(out_valid), 1);
    res("255/0", 16'hFFFF, 8'hFF, 1'b1);
    retire;

    start(16'd1234, 8'd9);
    wait_done(LAT);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_hs", {30'd0, in_ready, out_valid}, 32'b01);
      res("hold", mq(16'd1234, 8'd9), mr(16'd1234, 8'd9), 1'b0);
    end
    in_valid = 1'b0;
    retire;
    @(posedge clk); #1;
    chk("no_stray_accept", 32'(in_ready), 1);

    start(16'd1000, 8'd7);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_hs", {30'd0, in_ready, out_valid}, 32'b10);
    res("abort", 16'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start(16'd100, 8'd10);
    wait_done(LAT);
    res("100/10", mq(16'd100, 8'd10), 8'd0, 1'b0);
    retire;

    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [15:0] x;
      logic [7:0]  y;
      x = 16'($urandom);
      y = 8'($urandom_range(1, 255));
      start(x, y);
      wait_done(LAT);
      res("rand", mq(x, y), mr(x, y), 1'b0);
      @(posedge clk); #1;
      chk("one_idle_cycle", {30'd0, in_ready, out_valid}, 32'b10);
    end
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
